// File: rtl/dct_transpose_buf.sv
// Ping-pong transpose buffer between the row and column DCT passes.
// Blocks are written row-major from gapped strobes and replayed column-major with valid/ready.
module dct_transpose_buf #(
  parameter int DW    = 12,
  parameter int LOG2N = 3
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          overflow
);
  localparam int AW = 2*LOG2N;
  localparam int NE = 1 << AW;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  logic [DW-1:0] mem_q [2][NE];

  logic [1:0]    bank_full_q, bank_full_d;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, ovf_q, ovf_d;

  logic          load, rd_go, rd_last, wr_free, wr_go, wr_last;
  logic [AW-1:0] rd_addr;

  always_comb begin
    load    = !vld_q || dout_ready;
    rd_go   = load && bank_full_q[rd_bank_q];
    rd_last = rd_go && (rd_idx_q == LAST);
    // A bank whose final beat leaves this cycle may already take the next block's first sample.
    wr_free = !bank_full_q[wr_bank_q] || (rd_last && (rd_bank_q == wr_bank_q));
    wr_go   = din_valid && wr_free;
    wr_last = wr_go && (wr_idx_q == LAST);
    // Element (row = idx % N, col = idx / N) lives at row*N + col.
    rd_addr = {rd_idx_q[LOG2N-1:0], rd_idx_q[AW-1:LOG2N]};
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    dout_d      = dout_q;
    vld_d       = vld_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    ovf_d       = ovf_q | (din_valid && !wr_free);

    if (wr_go) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_last) wr_bank_d = ~wr_bank_q;
    end

    if (load) begin
      vld_d = rd_go;
      sop_d = rd_go && (rd_idx_q == '0);
      eop_d = rd_last;
      if (rd_go) begin
        dout_d   = mem_q[rd_bank_q][rd_addr];
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_last) rd_bank_d = ~rd_bank_q;
      end
    end

    if (rd_last) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_last) bank_full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      dout_q      <= dout_d;
      vld_q       <= vld_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && wr_go) mem_q[wr_bank_q][wr_idx_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: directed blocks, expected transposed beats queued,
// a negedge monitor pops and compares each accepted beat and checks stall stability.
module tb_dct_transpose_buf;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_sop, dout_eop, overflow;

  dct_transpose_buf #(.DW(12), .LOG2N(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [11:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       exp_q[$];
  logic [11:0] blk [64];
  int          n_cmp = 0, n_err = 0;
  int          sop_cnt = 0, eop_cnt = 0;
  bit          rnd_en = 0;

  // Monitor: every accepted beat is compared against the queue head.
  bit          stall_prev = 0;
  beat_t       held;
  initial begin
    beat_t e;
    forever begin
      @(negedge sys_clk);
      if (stall_prev) begin
        n_cmp++;
        if (dout_valid !== 1'b1 || {dout, dout_sop, dout_eop} !== held) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%0h sop=%b eop=%b expected v=1 d=%0h sop=%b eop=%b",
                   dout_valid, dout, dout_sop, dout_eop, held.d, held.sop, held.eop);
        end
      end
      stall_prev = sys_rst_n && dout_valid && !dout_ready;
      held = {dout, dout_sop, dout_eop};
      if (dout_valid && dout_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: got d=%0h sop=%b eop=%b expected no beat", dout, dout_sop, dout_eop);
        end else begin
          e = exp_q.pop_front();
          if ({dout, dout_sop, dout_eop} !== e) begin
            n_err++;
            $display("FAIL beat: got d=%0h sop=%b eop=%b expected d=%0h sop=%b eop=%b",
                     dout, dout_sop, dout_eop, e.d, e.sop, e.eop);
          end
        end
        if (dout_sop) sop_cnt++;
        if (dout_eop) eop_cnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rnd_en) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed_one(input logic [11:0] v);
    din = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic fill_lin(input int base);
    for (int i = 0; i < 64; i++) blk[i] = 12'(base + i);
  endtask

  task automatic feed_blk(input int gap, input int start);
    for (int i = start; i < 64; i++) begin
      feed_one(blk[i]);
      repeat (gap) tick();
    end
  endtask

  // Beat k of the output is element (row = k%8, col = k/8) of the row-major input.
  task automatic push_blk();
    beat_t e;
    for (int k = 0; k < 64; k++) begin
      e.d   = blk[(k % 8) * 8 + k / 8];
      e.sop = (k == 0);
      e.eop = (k == 63);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int  s0, e0;
    bit  found;

    // Reset state
    sys_rst_n = 1'b0;
    tick();
    tick();
    @(negedge sys_clk);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_sop_eop", {dout_sop, dout_eop}, 0);
    chk("rst_overflow", 32'(overflow), 0);
    tick();
    sys_rst_n = 1'b1;

    // 1: contiguous block, ready high, first-beat latency
    fill_lin(0);
    push_blk();
    feed_blk(0, 0);
    @(negedge sys_clk);
    chk("lat_valid_at_N", 32'(dout_valid), 0);
    @(negedge sys_clk);
    chk("lat_valid_at_N1", 32'(dout_valid), 1);
    wait_drain(500);

    // 2: same block with random backpressure
    push_blk();
    rnd_en = 1;
    feed_blk(0, 0);
    wait_drain(2000);
    rnd_en = 0;
    dout_ready = 1'b1;
    tick();

    // 3: two blocks, 1-of-4 gapped writes
    s0 = sop_cnt;
    e0 = eop_cnt;
    fill_lin(0);
    push_blk();
    feed_blk(3, 0);
    fill_lin(64);
    push_blk();
    feed_blk(3, 0);
    wait_drain(1000);
    chk("gap_sop_count", 32'(sop_cnt - s0), 2);
    chk("gap_eop_count", 32'(eop_cnt - e0), 2);
    chk("gap_overflow", 32'(overflow), 0);

    // 4: both banks filled under stall, 129th sample dropped
    dout_ready = 1'b0;
    fill_lin(0);
    push_blk();
    feed_blk(0, 0);
    fill_lin(64);
    push_blk();
    feed_blk(0, 0);
    @(negedge sys_clk);
    chk("ovf_before_drop", 32'(overflow), 0);
    feed_one(12'd128);
    @(negedge sys_clk);
    chk("ovf_after_drop", 32'(overflow), 1);
    tick();
    dout_ready = 1'b1;
    wait_drain(1000);
    @(negedge sys_clk);
    chk("ovf_drained_valid", 32'(dout_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // 5: write accepted into the bank whose last beat is loading
    do_reset();
    dout_ready = 1'b0;
    fill_lin(0);
    push_blk();
    feed_blk(0, 0);
    fill_lin(64);
    push_blk();
    feed_blk(0, 0);
    fill_lin(200);
    push_blk();
    dout_ready = 1'b1;
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge sys_clk);
      if (dout_valid && dout == 12'd47) found = 1;
    end
    chk("fsc_beat61_seen", 32'(found), 1);
    tick();
    feed_one(12'd200);
    @(negedge sys_clk);
    chk("fsc_overflow", 32'(overflow), 0);
    feed_blk(0, 1);
    wait_drain(1000);
    chk("fsc_overflow_end", 32'(overflow), 0);

    // 6: signed extremes, then reset mid-block
    do_reset();
    fill_lin(0);
    blk[1]  = 12'h800;
    blk[62] = 12'h7FF;
    push_blk();
    feed_blk(0, 0);
    wait_drain(500);
    fill_lin(500);
    for (int i = 0; i < 40; i++) feed_one(blk[i]);
    sys_rst_n = 1'b0;
    tick();
    @(negedge sys_clk);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_sop_eop_ovf", {dout_sop, dout_eop, overflow}, 0);
    tick();
    sys_rst_n = 1'b1;
    fill_lin(1000);
    push_blk();
    feed_blk(0, 0);
    wait_drain(500);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
Ping-pong transpose memory between the row-pass and column-pass 1-D DCT stages of the 8x8 MJPEG DCT. It collects the row-pass distributed-arithmetic coefficients, which arrive as single-cycle gapped strobes, row-major, 64 per block. It replays each complete block column-major to the column pass, with valid/ready flow control. Two banks let one block be written while the previous one is read.

Parameters:
DW, 12, coefficient width (signed two's complement, passed through unmodified)
LOG2N, 3, log2 of block side; block = 2^(2*LOG2N) = 64 entries

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset; synchronous, active-low
din  in  DW  signed row-pass coefficient
din_valid  in  1  write strobe, one sample per high cycle, arbitrary gaps
dout  out  DW  signed transposed coefficient
dout_valid  out  1  dout holds a valid beat
dout_ready  in  1  downstream accepts the beat when dout_valid and dout_ready are both high
dout_sop  out  1  high with the first beat of a block (element 0,0)
dout_eop  out  1  high with the last beat of a block (element 7,7)
overflow  out  1  sticky; a sample was dropped because both banks were full

Behaviour:
- Storage: mem[2][64] of DW bits; register array or inferred RAM.
- Control state:
  - bank_full[1:0]
  - wr_bank, with wr_idx 0..63
  - rd_bank, with rd_idx 0..63
- Reset, sampled on the sys_clk edge while sys_rst_n=0:
  - bank_full=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0.
  - dout=0, dout_valid=0, dout_sop=0, dout_eop=0, overflow=0.
  - Memory contents are don't-care.
  - Reset mid-block discards all partially written and unread data.
- Write path, on din_valid=1:
  - If the target bank is free (see free-same-cycle rule), then mem[wr_bank][wr_idx]<=din and wr_idx++.
  - When wr_idx==63: set bank_full[wr_bank], toggle wr_bank, wr_idx<=0.
  - If the target bank is full, the sample is dropped, overflow<=1 (stays 1 until reset), and pointers are unchanged.
- Read path:
  - Load condition: (dout_valid==0 || dout_ready==1).
  - When the load condition holds and bank_full[rd_bank]==1:
    - dout<=mem[rd_bank][{rd_idx[2:0],rd_idx[5:3]}], i.e. element (row=rd_idx%8, col=rd_idx/8).
    - dout_valid<=1, dout_sop<=(rd_idx==0), dout_eop<=(rd_idx==63), rd_idx++.
  - On the rd_idx==63 load: clear bank_full[rd_bank], toggle rd_bank, rd_idx<=0.
  - When the load condition holds and the bank is not full: dout_valid<=0, dout_sop<=0, dout_eop<=0.
  - While dout_valid=1 and dout_ready=0: dout, dout_sop and dout_eop hold stable.
- Free-same-cycle rule:
  - A bank whose last element is loaded into dout this cycle counts as free for a write in that same cycle.
  - Such a write is accepted, not dropped.
- Write completion and a read load on the other bank in the same cycle are independent; both take effect.
- Latency:
  - The 64th sample is sampled at edge N, so bank_full is set at edge N.
  - The first beat is registered at edge N+1, giving dout_valid=1 after edge N+1.
  - Throughput is 1 beat/cycle when dout_ready=1.
  - Back-to-back blocks are output contiguously with no idle cycle if the next bank is already full.
- Read and write never target the same bank simultaneously: the writer only uses a non-full bank, and the reader only uses a full bank.
- Arithmetic: none; data are bit-exact, sign preserved.

Test Plan:
1. Reset, then 64 samples din=0..63 on consecutive cycles, dout_ready=1:
   - Outputs are 0,8,16,..,56,1,9,..,63.
   - dout_sop with 0, dout_eop with 63.
   - dout_valid first high one cycle after bank_full sets.
2. Same block, dout_ready pseudo-random (about 50%):
   - Identical 64-value sequence, no duplicates or losses.
   - dout, dout_sop and dout_eop stable while stalled.
3. 128 samples (din=0..127) with din_valid gapped 1-of-4, dout_ready=1:
   - Block 2 outputs 64,72,..,127.
   - Exactly two sop and two eop pulses.
   - overflow=0.
4. dout_ready=0, feed 129 samples:
   - The 129th is dropped and overflow=1.
   - Then dout_ready=1 gives exactly 128 beats (0..127 transposed), then dout_valid=0.
5. Free-same-cycle: with both banks full, drive din_valid in the cycle the 64th beat of bank 0 loads into dout:
   - The sample is accepted into bank 0 at index 0.
   - overflow stays 0.
6. Signed extremes din=-2048 and 2047 at positions (0,1) and (7,6):
   - They appear unchanged at output beats 8 and 55.
   - Reset asserted after 40 writes: all outputs 0 the next cycle, and the following 64 samples form a fresh block starting at sop.
